spi_reg_loader: RTL and testbench

- SPI slave front end feeding the oscillator register bank's write port: `load`, `address[2:0]`, `data_in[7:0]`.
- Deserialises 16-bit host frames, oversampled on the system clock, and issues one single-cycle write strobe per valid write frame.
- Read frames shift back a register byte supplied combinationally by the register bank via `rd_addr` / `rd_data`.

---
 rtl/spi_reg_loader.sv | 195 +++++++++++++++++++
 tb/tb_spi_reg_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_loader.sv
// SPI mode-0 slave that turns 8+DATA_W bit host frames into register-bank write strobes and read-backs.
// Optional build macro SPI_LOADER_BURST_EN: write frames may continue with auto-incrementing addresses.
module spi_reg_loader #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              load,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              frame_err
);

  // state     | meaning
  // WAIT_IDLE | after reset; waits for cs_n high so a half-seen frame is dropped
  // IDLE      | no frame; bit counter and shift register held clear
  // SHIFT     | frame in progress; bits shifted in on sclk rising edges
  // COMMIT    | one cycle: issue load or frame_err from the final bit count
  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  localparam int         FRAME_W   = 8 + DATA_W;
  localparam logic [4:0] FRAME_CNT = 5'(FRAME_W);
  localparam logic [4:0] LAST_CNT  = 5'(FRAME_W - 1);
  localparam logic [4:0] HDR_CNT   = 5'd8;
  localparam logic [4:0] HDR_LAST  = 5'd7;
  localparam logic [4:0] CNT_MAX   = 5'd31;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s, sclk_d;
  logic                   sclk_rise, sclk_fall, shift_en;
  logic [1:0]             state, state_nxt;
  logic [4:0]             cnt;
  logic [FRAME_W-1:0]     shreg;
  logic [DATA_W-1:0]      tx;
  logic                   is_read, cap_pend;
`ifdef SPI_LOADER_BURST_EN
  localparam int              BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  logic          shifted;
  logic [BW-1:0] burst_cnt;
`endif

  // cs_n synchroniser resets low so WAIT_IDLE only leaves on a real high level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  // an sclk edge coinciding with cs_n release is discarded
  assign shift_en  = (state == SHIFT) && sclk_rise && !cs_s;
  assign busy      = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (cs_s)  state_nxt = IDLE;
      IDLE:      if (!cs_s) state_nxt = SHIFT;
      SHIFT:     if (cs_s)  state_nxt = COMMIT;
      COMMIT:               state_nxt = IDLE;
      default:              state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      shreg     <= '0;
      tx        <= '0;
      is_read   <= 1'b0;
      cap_pend  <= 1'b0;
      miso      <= 1'b0;
      rd_addr   <= '0;
      load      <= 1'b0;
      address   <= '0;
      data_out  <= '0;
      frame_err <= 1'b0;
`ifdef SPI_LOADER_BURST_EN
      shifted   <= 1'b0;
      burst_cnt <= '0;
`endif
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      cap_pend  <= 1'b0;
`ifdef SPI_LOADER_BURST_EN
      shifted   <= shift_en;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          shreg   <= '0;
          is_read <= 1'b0;
          miso    <= 1'b0;
`ifdef SPI_LOADER_BURST_EN
          burst_cnt <= '0;
`endif
        end
        SHIFT: begin
          if (shift_en) begin
            shreg <= {shreg[FRAME_W-2:0], mosi_s};
            cnt   <= (cnt == CNT_MAX) ? cnt : cnt + 5'd1;
            // header completes on this edge: latch the read address for the bank
            if (cnt == HDR_LAST && shreg[6]) begin
              is_read  <= 1'b1;
              rd_addr  <= ADDR_W'({shreg[6:0], mosi_s});
              cap_pend <= 1'b1;
            end
          end
          if (sclk_fall) begin
            if (is_read && cnt >= HDR_CNT && cnt <= LAST_CNT) begin
              miso <= tx[DATA_W-1];
              tx   <= {tx[DATA_W-2:0], 1'b0};
            end else begin
              miso <= 1'b0;
            end
          end
`ifdef SPI_LOADER_BURST_EN
          if (shifted && !is_read) begin
            if (cnt == FRAME_CNT) begin
              load      <= 1'b1;
              address   <= shreg[DATA_W+ADDR_W-1:DATA_W];
              data_out  <= shreg[DATA_W-1:0];
              burst_cnt <= '0;
            end else if (cnt > FRAME_CNT) begin
              if (burst_cnt == BW'(DATA_W - 1)) begin
                load      <= 1'b1;
                address   <= address + ADDR_ONE;
                data_out  <= shreg[DATA_W-1:0];
                burst_cnt <= '0;
              end else begin
                burst_cnt <= burst_cnt + BW'(1);
              end
            end
          end
`endif
        end
        COMMIT: begin
          miso <= 1'b0;
`ifdef SPI_LOADER_BURST_EN
          // writes were already committed while shifting; only a partial tail is an error
          if (!is_read && cnt >= FRAME_CNT) begin
            if (burst_cnt != '0) frame_err <= 1'b1;
          end else if (!(is_read && cnt == FRAME_CNT)) begin
            frame_err <= 1'b1;
          end
`else
          if (cnt == FRAME_CNT) begin
            if (!is_read) begin
              load     <= 1'b1;
              address  <= shreg[DATA_W+ADDR_W-1:DATA_W];
              data_out <= shreg[DATA_W-1:0];
            end
          end else begin
            frame_err <= 1'b1;
          end
`endif
        end
        default: miso <= 1'b0;
      endcase
      if (cap_pend) tx <= rd_data;
    end
  end

endmodule

// File: tb/tb_spi_reg_loader.sv
// Directed + random bench for spi_reg_loader; a scoreboard queue holds the expected write strobes.
module tb_spi_reg_loader;
  localparam int ADDR_W      = 3;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sclk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              frame_err;

  spi_reg_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rd_data(rd_data), .rd_addr(rd_addr), .load(load), .address(address),
    .data_out(data_out), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // register bank model: address 5 holds 0x1B, everything else 0xE4
  assign rd_data = (rd_addr == 3'd5) ? 8'h1B : 8'hE4;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int load_cnt = 0;
  logic [10:0] sb[$];
  logic [10:0] exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (frame_err === 1'b1) err_cnt++;
    if (load === 1'b1) begin
      load_cnt++;
      if (sb.size() == 0) begin
        check("load_unexpected", 32'(load), 32'd0);
      end else begin
        exp_w = sb.pop_front();
        check("load_fields", {21'd0, address, data_out}, {21'd0, exp_w});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_load"}, 32'(load), 32'd0);
    check({tag, "_address"}, 32'(address), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // drive one frame (cs_n stays low at the end); miso sampled just before each rising edge
  task automatic xfer(input logic [31:0] word, input int nbits, input int half, input bit junk,
                      input int rst_at, output logic [31:0] mcap);
    mcap = '0;
    cs_n = 1'b0;
    mosi = word[nbits-1];
    clks(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset_n = 1'b0;
        clks(2);
        check_reset_vals("midframe_reset");
        reset_n = 1'b1;
        clks(1);
      end
      if (i == 1 && rst_at < 0) check("busy_in_frame", 32'(busy), 32'd1);
      mcap = {mcap[30:0], miso};
      sclk = 1'b1;
      if (junk) begin
        clks(1);
        mosi = 1'($urandom);
        clks(half - 1);
      end else begin
        clks(half);
      end
      sclk = 1'b0;
      mosi = (i + 1 < nbits) ? word[nbits-2-i] : 1'b0;
      clks(half);
    end
  endtask

  // release cs_n and report the cycle on which load was first seen (0 = none)
  task automatic finish_frame(output int lat);
    cs_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (load === 1'b1 && lat == 0) lat = k;
    end
    clks(4);
  endtask

  logic [31:0] m;
  int lat;
  int e0, l0;
  logic [2:0] ra;
  logic [7:0] rdat;
  logic [3:0] rsv;

  initial begin
    clks(3);
    check_reset_vals("reset");
    reset_n = 1'b1;
    clks(4);
    check("idle_busy", 32'(busy), 32'd0);

    // write 0x047D
    e0 = err_cnt;
    sb.push_back({3'd4, 8'h7D});
    xfer(32'h047D, 16, 6, 1'b0, -1, m);
    finish_frame(lat);
`ifdef SPI_LOADER_BURST_EN
    check("write_latency", 32'(lat), 32'd0);
`else
    check("write_latency", 32'(lat), 32'(SYNC_STAGES + 2));
`endif
    check("write_busy_after", 32'(busy), 32'd0);
    check("write_no_err", 32'(err_cnt - e0), 32'd0);
    check("write_load_cnt", 32'(load_cnt), 32'd1);
    check("write_address_hold", 32'(address), 32'd4);
    check("write_data_hold", 32'(data_out), 32'h7D);

    // read 0x8500
    e0 = err_cnt;
    xfer(32'h8500, 16, 6, 1'b0, -1, m);
    finish_frame(lat);
    check("read_rd_addr", 32'(rd_addr), 32'd5);
    check("read_miso_bits", {16'd0, m[15:0]}, 32'h001B);
    check("read_miso_idle", 32'(miso), 32'd0);
    check("read_no_err", 32'(err_cnt - e0), 32'd0);
    check("read_no_load", 32'(load_cnt), 32'd1);

    // aborted write after 10 bits
    e0 = err_cnt;
    xfer(32'h00A5, 10, 6, 1'b0, -1, m);
    finish_frame(lat);
    check("abort_err", 32'(err_cnt - e0), 32'd1);
    check("abort_no_load", 32'(load_cnt), 32'd1);
    check("abort_address_hold", 32'(address), 32'd4);
    check("abort_data_hold", 32'(data_out), 32'h7D);

    // reset asserted at bit 6 of 0x0310, frame finishes with no effect
    e0 = err_cnt;
    l0 = load_cnt;
    xfer(32'h0310, 16, 6, 1'b0, 6, m);
    finish_frame(lat);
    check("rst_frame_no_err", 32'(err_cnt - e0), 32'd0);
    check("rst_frame_no_load", 32'(load_cnt - l0), 32'd0);
    sb.push_back({3'd3, 8'h10});
    xfer(32'h0310, 16, 6, 1'b0, -1, m);
    finish_frame(lat);
    check("after_rst_load", 32'(load_cnt - l0), 32'd1);
    check("after_rst_no_err", 32'(err_cnt - e0), 32'd0);

    // 24-bit frame 0x0610AA
    e0 = err_cnt;
    l0 = load_cnt;
`ifdef SPI_LOADER_BURST_EN
    sb.push_back({3'd6, 8'h10});
    sb.push_back({3'd7, 8'hAA});
`endif
    xfer(32'h0610AA, 24, 6, 1'b0, -1, m);
    finish_frame(lat);
`ifdef SPI_LOADER_BURST_EN
    check("long_frame_err", 32'(err_cnt - e0), 32'd0);
    check("long_frame_loads", 32'(load_cnt - l0), 32'd2);
`else
    check("long_frame_err", 32'(err_cnt - e0), 32'd1);
    check("long_frame_loads", 32'(load_cnt - l0), 32'd0);
`endif

    // random writes at clk/8 with mosi junk shortly after each rising edge
    e0 = err_cnt;
    l0 = load_cnt;
    for (int f = 0; f < 50; f++) begin
      ra   = 3'($urandom_range(0, 7));
      rdat = 8'($urandom);
      rsv  = 4'($urandom);
      sb.push_back({ra, rdat});
      xfer({16'd0, 1'b0, rsv, ra, rdat}, 16, 4, 1'b1, -1, m);
      finish_frame(lat);
    end
    check("random_loads", 32'(load_cnt - l0), 32'd50);
    check("random_no_err", 32'(err_cnt - e0), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
